// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel allocator and its request arbiter.
package falafel_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Modular step used by the round-robin search to wrap past the last client.
  function automatic int rr_wrap(input int base, input int offset, input int modulus);
    return (base + offset) % modulus;
  endfunction

endpackage

// File: rtl/falafel_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Returns a one-hot grant, its index, and whether anything was found.
module falafel_rr_picker
  import falafel_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'(rr_wrap(int'(ptr), i, NUM_REQ));
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/falafel_req_arbiter.sv
// Round-robin front-end serialising client alloc/free requests into falafel.
// Optional statistics counters are enabled with `define FALAFEL_ARB_STATS_EN.
module falafel_req_arbiter
  import falafel_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int CLIENT_W    = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CLIENTS-1:0]        cli_req_val_i,
  output logic [NUM_CLIENTS-1:0]        cli_req_rdy_o,
  input  logic [NUM_CLIENTS-1:0]        cli_req_is_alloc_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_req_data_i,
  output logic [NUM_CLIENTS-1:0]        cli_rsp_val_o,
  input  logic [NUM_CLIENTS-1:0]        cli_rsp_rdy_i,
  output logic [DATA_W-1:0]             cli_rsp_data_o,
  output logic                          cli_rsp_is_write_o,
  output logic                          fal_is_alloc_o,
  output logic [DATA_W-1:0]             fal_size_o,
  output logic [DATA_W-1:0]             fal_addr_o,
  output logic                          fal_req_val_o,
  input  logic                          fal_rsp_val_i,
  input  logic                          fal_rsp_is_write_i,
  input  logic [DATA_W-1:0]             fal_rsp_data_i,
  output logic                          fal_rsp_rdy_o,
  output logic [31:0]                   stat_alloc_o,
  output logic [31:0]                   stat_free_o,
  output logic [31:0]                   stat_fail_o
);

  arb_state_t               state;
  logic [CLIENT_W-1:0]      rr_ptr;
  logic [CLIENT_W-1:0]      idx_q;
  logic                     is_alloc_q;
  logic [DATA_W-1:0]        data_q;
  logic [DATA_W-1:0]        rsp_data_q;
  logic                     rsp_is_write_q;

  logic [NUM_CLIENTS-1:0]   pick_grant;
  logic [CLIENT_W-1:0]      pick_idx;
  logic                     pick_found;
  logic [DATA_W-1:0]        sel_data;
  logic                     sel_is_alloc;
  logic [NUM_CLIENTS-1:0]   sel_onehot;
  logic                     req_hs;
  logic                     rsp_hs;

  falafel_rr_picker #(
    .NUM_REQ (NUM_CLIENTS),
    .IDX_W   (CLIENT_W)
  ) u_picker (
    .req   (cli_req_val_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign sel_data     = cli_req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
  assign sel_is_alloc = cli_req_is_alloc_i[pick_idx];
  assign sel_onehot   = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << idx_q;

  assign req_hs = (state == IDLE) && pick_found;
  assign rsp_hs = (state == RESP) && cli_rsp_rdy_i[idx_q];

  assign cli_req_rdy_o = (state == IDLE) ? pick_grant : '0;

  // Only the field selected by is_alloc carries data; the other stays 0.
  assign fal_req_val_o  = (state == ISSUE);
  assign fal_is_alloc_o = (state == ISSUE) && is_alloc_q;
  assign fal_size_o     = ((state == ISSUE) && is_alloc_q)  ? data_q : '0;
  assign fal_addr_o     = ((state == ISSUE) && !is_alloc_q) ? data_q : '0;
  assign fal_rsp_rdy_o  = (state == WAIT);

  assign cli_rsp_val_o      = (state == RESP) ? sel_onehot : '0;
  assign cli_rsp_data_o     = rsp_data_q;
  assign cli_rsp_is_write_o = rsp_is_write_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      idx_q          <= '0;
      is_alloc_q     <= 1'b0;
      data_q         <= '0;
      rsp_data_q     <= '0;
      rsp_is_write_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_hs) begin
            idx_q      <= pick_idx;
            is_alloc_q <= sel_is_alloc;
            data_q     <= sel_data;
            // Zero-size allocs are answered here and never reach falafel.
            if (sel_is_alloc && (sel_data == '0)) begin
              rsp_data_q     <= '0;
              rsp_is_write_q <= 1'b0;
              state          <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (fal_rsp_val_i) begin
            rsp_data_q     <= fal_rsp_data_i;
            rsp_is_write_q <= fal_rsp_is_write_i;
            state          <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rr_ptr <= (idx_q == CLIENT_W'(NUM_CLIENTS-1)) ? '0 : idx_q + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FALAFEL_ARB_STATS_EN
  logic [31:0] stat_alloc_q;
  logic [31:0] stat_free_q;
  logic [31:0] stat_fail_q;

  // Saturating counters bumped when the client takes the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_alloc_q <= '0;
      stat_free_q  <= '0;
      stat_fail_q  <= '0;
    end else if (rsp_hs) begin
      if (is_alloc_q) begin
        if (stat_alloc_q != 32'hFFFF_FFFF) stat_alloc_q <= stat_alloc_q + 32'd1;
        if ((rsp_data_q == '0) && (stat_fail_q != 32'hFFFF_FFFF))
          stat_fail_q <= stat_fail_q + 32'd1;
      end else if (stat_free_q != 32'hFFFF_FFFF) begin
        stat_free_q <= stat_free_q + 32'd1;
      end
    end
  end

  assign stat_alloc_o = stat_alloc_q;
  assign stat_free_o  = stat_free_q;
  assign stat_fail_o  = stat_fail_q;
`else
  assign stat_alloc_o = '0;
  assign stat_free_o  = '0;
  assign stat_fail_o  = '0;
`endif

endmodule
